// File: rtl/spu_sub.sv
// rtl/spu_sub.sv - signed pipelined subtractor with overflow detect, optional saturation and sticky status
module spu_sub #(
  parameter int LATENCY      = 1,
  parameter int S_DATA0_BITS = 8,
  parameter int S_DATA1_BITS = 8,
  parameter int M_DATA_BITS  = 8,
  parameter int SATURATE     = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cke,
  input  logic                           s_valid,
  input  logic signed [S_DATA0_BITS-1:0] s_data0,
  input  logic signed [S_DATA1_BITS-1:0] s_data1,
  output logic                           m_valid,
  output logic signed [M_DATA_BITS-1:0]  m_data,
  output logic                           m_overflow,
  input  logic                           sticky_clear,
  output logic                           sticky_overflow
);

  // One guard bit above the widest operand keeps the difference exact.
  localparam int IN_MAX = (S_DATA0_BITS > S_DATA1_BITS) ? S_DATA0_BITS : S_DATA1_BITS;
  localparam int W      = ((IN_MAX > M_DATA_BITS) ? IN_MAX : M_DATA_BITS) + 1;

  // Result range limits expressed at the internal width.
  localparam logic signed [W-1:0] MAX_V =
    $signed({{(W-M_DATA_BITS+1){1'b0}}, {(M_DATA_BITS-1){1'b1}}});
  localparam logic signed [W-1:0] MIN_V =
    $signed({{(W-M_DATA_BITS+1){1'b1}}, {(M_DATA_BITS-1){1'b0}}});

  logic signed [W-1:0]           a_ext;
  logic signed [W-1:0]           b_ext;
  logic signed [W-1:0]           diff;
  logic                          ovf_pos;
  logic                          ovf_neg;
  logic                          s0_ovf;
  logic        [M_DATA_BITS-1:0] s0_data;

  assign a_ext   = W'(s_data0);
  assign b_ext   = W'(s_data1);
  assign diff    = a_ext - b_ext;
  assign ovf_pos = diff > MAX_V;
  assign ovf_neg = diff < MIN_V;
  assign s0_ovf  = ovf_pos | ovf_neg;

  // Stage 0: wrap or clamp the exact difference into the result width.
  always_comb begin
    s0_data = diff[M_DATA_BITS-1:0];
    if (SATURATE != 0) begin
      if (ovf_pos) begin
        s0_data = MAX_V[M_DATA_BITS-1:0];
      end else if (ovf_neg) begin
        s0_data = MIN_V[M_DATA_BITS-1:0];
      end
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign m_valid    = s_valid;
      assign m_data     = s0_data;
      assign m_overflow = s0_ovf;
    end else begin : g_pipe
      logic                   v_q [LATENCY];
      logic [M_DATA_BITS-1:0] d_q [LATENCY];
      logic                   o_q [LATENCY];

      // Shift chain of {valid, data, overflow}; data loads even on bubbles.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < LATENCY; i++) begin
            v_q[i] <= 1'b0;
            d_q[i] <= '0;
            o_q[i] <= 1'b0;
          end
        end else if (cke) begin
          v_q[0] <= s_valid;
          d_q[0] <= s0_data;
          o_q[0] <= s0_ovf;
          for (int i = 1; i < LATENCY; i++) begin
            v_q[i] <= v_q[i-1];
            d_q[i] <= d_q[i-1];
            o_q[i] <= o_q[i-1];
          end
        end
      end

      assign m_valid    = v_q[LATENCY-1];
      assign m_data     = d_q[LATENCY-1];
      assign m_overflow = o_q[LATENCY-1];
    end
  endgenerate

  // Sticky overflow: a qualified overflow at the output beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_overflow <= 1'b0;
    end else if (cke) begin
      if (m_valid && m_overflow) begin
        sticky_overflow <= 1'b1;
      end else if (sticky_clear) begin
        sticky_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spu_sub.sv
// tb/tb_spu_sub.sv - randomized and directed bench for spu_sub against an arithmetic reference model
module tb_spu_sub;

  localparam int N = 4;
  // Instances: 0 = LAT3 wrap, 1 = LAT1 saturate, 2 = LAT0 wrap, 3 = LAT2 wide (6/4 -> 10 bits)
  localparam int LAT [N] = '{3, 1, 0, 2};
  localparam int B0  [N] = '{8, 8, 8, 6};
  localparam int B1  [N] = '{8, 8, 8, 4};
  localparam int MB  [N] = '{8, 8, 8, 10};
  localparam int SAT [N] = '{0, 1, 0, 0};

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              cke = 1'b0;
  logic              s_valid = 1'b0;
  logic signed [7:0] s_data0 = '0;
  logic signed [7:0] s_data1 = '0;
  logic              sticky_clear = 1'b0;

  logic              mv_l3, mo_l3, st_l3;
  logic signed [7:0] md_l3;
  logic              mv_sat, mo_sat, st_sat;
  logic signed [7:0] md_sat;
  logic              mv_l0, mo_l0, st_l0;
  logic signed [7:0] md_l0;
  logic              mv_w, mo_w, st_w;
  logic signed [9:0] md_w;

  logic              mv [N];
  logic              mo [N];
  logic              st [N];
  logic signed [31:0] mdv [N];

  assign mv[0] = mv_l3;  assign mo[0] = mo_l3;  assign st[0] = st_l3;  assign mdv[0] = 32'(md_l3);
  assign mv[1] = mv_sat; assign mo[1] = mo_sat; assign st[1] = st_sat; assign mdv[1] = 32'(md_sat);
  assign mv[2] = mv_l0;  assign mo[2] = mo_l0;  assign st[2] = st_l0;  assign mdv[2] = 32'(md_l0);
  assign mv[3] = mv_w;   assign mo[3] = mo_w;   assign st[3] = st_w;   assign mdv[3] = 32'(md_w);

  spu_sub #(.LATENCY(3), .S_DATA0_BITS(8), .S_DATA1_BITS(8), .M_DATA_BITS(8), .SATURATE(0)) u_l3 (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_valid(s_valid), .s_data0(s_data0), .s_data1(s_data1),
    .m_valid(mv_l3), .m_data(md_l3), .m_overflow(mo_l3), .sticky_clear(sticky_clear), .sticky_overflow(st_l3));

  spu_sub #(.LATENCY(1), .S_DATA0_BITS(8), .S_DATA1_BITS(8), .M_DATA_BITS(8), .SATURATE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_valid(s_valid), .s_data0(s_data0), .s_data1(s_data1),
    .m_valid(mv_sat), .m_data(md_sat), .m_overflow(mo_sat), .sticky_clear(sticky_clear), .sticky_overflow(st_sat));

  spu_sub #(.LATENCY(0), .S_DATA0_BITS(8), .S_DATA1_BITS(8), .M_DATA_BITS(8), .SATURATE(0)) u_l0 (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_valid(s_valid), .s_data0(s_data0), .s_data1(s_data1),
    .m_valid(mv_l0), .m_data(md_l0), .m_overflow(mo_l0), .sticky_clear(sticky_clear), .sticky_overflow(st_l0));

  spu_sub #(.LATENCY(2), .S_DATA0_BITS(6), .S_DATA1_BITS(4), .M_DATA_BITS(10), .SATURATE(0)) u_wide (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_valid(s_valid), .s_data0(s_data0[5:0]), .s_data1(s_data1[3:0]),
    .m_valid(mv_w), .m_data(md_w), .m_overflow(mo_w), .sticky_clear(sticky_clear), .sticky_overflow(st_w));

  always #5 clk = ~clk;

  typedef struct { bit v; int a; int b; } samp_t;
  samp_t hist[$];
  bit    sticky_exp [N];
  bit    cur_v;
  int    cur_a, cur_b;
  int    checks = 0;
  int    errors = 0;

  // Interpret the low 'bits' bits of x as a two's-complement number.
  function automatic int sx(input int x, input int bits);
    int u;
    u = x & ((1 << bits) - 1);
    return (u >= (1 << (bits - 1))) ? u - (1 << bits) : u;
  endfunction

  // Expected outputs of instance k: the sample accepted LAT cke edges ago.
  function automatic void expect_out(input int k, output bit ev, output int ed, output bit eo);
    bit v;
    int a, b, d, mx, mn;
    if (LAT[k] == 0) begin
      v = cur_v; a = cur_a; b = cur_b;
    end else if (hist.size() < LAT[k]) begin
      ev = 1'b0; ed = 0; eo = 1'b0;
      return;
    end else begin
      v = hist[hist.size() - LAT[k]].v;
      a = hist[hist.size() - LAT[k]].a;
      b = hist[hist.size() - LAT[k]].b;
    end
    d  = sx(a, B0[k]) - sx(b, B1[k]);
    mx = (1 << (MB[k] - 1)) - 1;
    mn = -(1 << (MB[k] - 1));
    eo = (d > mx) || (d < mn);
    if (SAT[k] != 0) ed = (d > mx) ? mx : ((d < mn) ? mn : d);
    else             ed = sx(d, MB[k]);
    ev = v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit ev, eo;
    int ed;
    for (int k = 0; k < N; k++) begin
      expect_out(k, ev, ed, eo);
      chk($sformatf("%s_u%0d_valid", tag, k), 32'(mv[k]), 32'(ev));
      if (ev) begin
        chk($sformatf("%s_u%0d_data", tag, k), mdv[k], ed);
        chk($sformatf("%s_u%0d_ovf", tag, k), 32'(mo[k]), 32'(eo));
      end
      chk($sformatf("%s_u%0d_sticky", tag, k), 32'(st[k]), 32'(sticky_exp[k]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_u%0d_valid", tag, k), 32'(mv[k]), 0);
      chk($sformatf("%s_u%0d_data", tag, k), mdv[k], 0);
      chk($sformatf("%s_u%0d_ovf", tag, k), 32'(mo[k]), 0);
      chk($sformatf("%s_u%0d_sticky", tag, k), 32'(st[k]), 0);
    end
  endtask

  // One clock: drive inputs, check LAT0 comb path, clock, update model, check all.
  task automatic step(input string tag, input bit v, input int a, input int b, input bit ce, input bit clr);
    bit ev, eo;
    int ed;
    bit pre_hit [N];
    s_valid = v; s_data0 = 8'(a); s_data1 = 8'(b); cke = ce; sticky_clear = clr;
    cur_v = v; cur_a = a; cur_b = b;
    #1;
    for (int k = 0; k < N; k++) begin
      expect_out(k, ev, ed, eo);
      pre_hit[k] = ev && eo;
    end
    check_all({tag, "_pre"});
    @(posedge clk);
    if (ce) begin
      for (int k = 0; k < N; k++) begin
        if (pre_hit[k])  sticky_exp[k] = 1'b1;
        else if (clr)    sticky_exp[k] = 1'b0;
      end
      hist.push_back('{v: v, a: a, b: b});
      if (hist.size() > 8) void'(hist.pop_front());
    end
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < N; k++) sticky_exp[k] = 1'b0;
  endtask

  initial begin
    cur_v = 1'b0; cur_a = 0; cur_b = 0;
    model_reset();

    // Reset state
    #2 reset_n = 1'b0;
    #1 check_zero("reset");
    @(posedge clk); @(posedge clk);
    #2 reset_n = 1'b1;

    // Basic 20-7 through each latency, then bubbles
    step("basic", 1, 20, 7, 1, 0);
    for (int i = 0; i < 4; i++) step("basic_idle", 0, 0, 0, 1, 0);

    // Wrap and saturation boundaries
    step("ovf_pos", 1, 100, -50, 1, 0);
    step("ovf_neg", 1, -128, 1, 1, 0);
    step("min_min", 1, -128, -128, 1, 0);
    step("max_min", 1, 127, -128, 1, 0);
    for (int i = 0; i < 4; i++) step("ovf_idle", 0, 0, 0, 1, 0);

    // Sticky clear race: overflow arrives on the same edge as clear
    step("race_in", 1, 100, -50, 1, 1);
    for (int i = 0; i < 5; i++) step("race_clr", 0, 0, 0, 1, 1);
    step("race_end", 0, 0, 0, 1, 0);

    // cke stall mid-flight
    step("stall_a", 1, 5, 1, 1, 0);
    step("stall_b", 1, 9, 3, 1, 0);
    for (int i = 0; i < 4; i++) step("stall_hold", 1, 55, -60, 0, 1);
    for (int i = 0; i < 4; i++) step("stall_go", 0, 0, 0, 1, 0);

    // Reset mid-stream with samples in flight
    step("rst_a", 1, 10, 2, 1, 0);
    step("rst_b", 1, 120, -100, 1, 0);
    step("rst_c", 1, 30, 4, 1, 0);
    s_valid = 1'b0; s_data0 = '0; s_data1 = '0; cur_v = 1'b0; cur_a = 0; cur_b = 0;
    #2 reset_n = 1'b0;
    #1 check_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step("rst_after", 0, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand",
           1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128,
           1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
